mem_req: RTL and testbench

- AXI4-Lite request-issue stage that sits between the execute stage and the load/store unit.
- Accepts one load or store request from execute and drives the AR channel, or the AW and W channels, to memory.
- Aligns write data and strobes to byte lanes and rejects misaligned accesses.
- Allows one transaction in flight; the load/store unit consumes the R/B response and returns a completion pulse.

---
 rtl/mem_req_pkg.sv | 38 +++
 rtl/mem_lane_align.sv | 26 ++
 rtl/mem_req.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_req.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared encodings for the mem_req AXI4-Lite request-issue stage: access sizes,
// FSM states and AXI response codes.
package mem_req_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_RD_ADDR      = 2'd1,
        ST_WR_ADDR_DATA = 2'd2,
        ST_WAIT_RESP    = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unshifted byte-lane mask for an access size (lane 0 based).
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size_e'(size))
            SIZE_B:  mask = 4'b0001;
            SIZE_H:  mask = 4'b0011;
            SIZE_W:  mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: shifts LSB-justified data to its lanes,
// builds the strobe and flags accesses that are not naturally aligned.
module mem_lane_align
    import mem_req_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        misaligned_o
);

    // Lane shift, strobe generation and natural-alignment check.
    always_comb begin
        wdata_o = wdata_i << {addr_lo_i, 3'b000};
        wstrb_o = size_mask(size_i) << addr_lo_i;
        case (size_e'(size_i))
            SIZE_B:  misaligned_o = 1'b0;
            SIZE_H:  misaligned_o = addr_lo_i[0];
            SIZE_W:  misaligned_o = (addr_lo_i != 2'b00);
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_req.sv
// AXI4-Lite request-issue stage: one load (AR) or store (AW+W) in flight.
// Define MEM_REQ_PERF_EN to add saturating AR / AW-W stall counters.
module mem_req
    import mem_req_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic              resp_done_i,
    output logic              misalign_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [2:0]        arsize_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [2:0]        awsize_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [3:0]        wstrb_o,
    output logic              wvalid_o,
    input  logic              wready_i
`ifdef MEM_REQ_PERF_EN
    ,
    output logic [31:0]       ar_stall_cnt_o,
    output logic [31:0]       aw_stall_cnt_o
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              arvalid_q, arvalid_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              misalign_q, misalign_d;

    logic              accept_s, ar_hs_s, aw_hs_s, w_hs_s, wr_all_s;
    logic [DATA_W-1:0] al_wdata_s;
    logic [3:0]        al_wstrb_s;
    logic              al_misaligned_s;

    mem_lane_align u_align (
        .size_i       (req_size_i),
        .addr_lo_i    (req_addr_i[1:0]),
        .wdata_i      (req_wdata_i),
        .wdata_o      (al_wdata_s),
        .wstrb_o      (al_wstrb_s),
        .misaligned_o (al_misaligned_s)
    );

    assign accept_s = req_valid_i & (state_q == ST_IDLE);
    assign ar_hs_s  = arvalid_q & arready_i;
    assign aw_hs_s  = awvalid_q & awready_i;
    assign w_hs_s   = wvalid_q & wready_i;
    // Both write channels finished, counting a handshake landing this cycle.
    assign wr_all_s = (aw_done_q | aw_hs_s) & (w_done_q | w_hs_s);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !al_misaligned_s) begin
                    state_d = req_we_i ? ST_WR_ADDR_DATA : ST_RD_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs_s) state_d = ST_WAIT_RESP;
                else         state_d = ST_RD_ADDR;
            end
            ST_WR_ADDR_DATA: begin
                if (wr_all_s) state_d = ST_WAIT_RESP;
                else          state_d = ST_WR_ADDR_DATA;
            end
            ST_WAIT_RESP: begin
                if (resp_done_i) state_d = ST_IDLE;
                else             state_d = ST_WAIT_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/payload next values; payload only loads on acceptance so it is stable while valid.
    always_comb begin
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        arvalid_d  = arvalid_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && al_misaligned_s) begin
                    misalign_d = 1'b1;
                end else if (accept_s) begin
                    addr_d = req_addr_i;
                    size_d = req_size_i;
                    if (req_we_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        wdata_d   = al_wdata_s;
                        wstrb_d   = al_wstrb_s;
                    end else begin
                        arvalid_d = 1'b1;
                    end
                end else begin
                    misalign_d = 1'b0;
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs_s) arvalid_d = 1'b0;
                else         arvalid_d = arvalid_q;
            end
            ST_WR_ADDR_DATA: begin
                if (aw_hs_s) awvalid_d = 1'b0;
                else         awvalid_d = awvalid_q;
                if (w_hs_s)  wvalid_d = 1'b0;
                else         wvalid_d = wvalid_q;
                if (wr_all_s) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs_s;
                    w_done_d  = w_done_q | w_hs_s;
                end
            end
            default: begin
                misalign_d = 1'b0;
            end
        endcase
    end

    // Output and payload registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            size_q     <= 2'b00;
            wdata_q    <= '0;
            wstrb_q    <= 4'b0000;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            arvalid_q  <= arvalid_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            misalign_q <= misalign_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign misalign_o  = misalign_q;
    assign araddr_o    = addr_q;
    assign awaddr_o    = addr_q;
    assign arsize_o    = {1'b0, size_q};
    assign awsize_o    = {1'b0, size_q};
    assign arvalid_o   = arvalid_q;
    assign awvalid_o   = awvalid_q;
    assign wvalid_o    = wvalid_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;

`ifdef MEM_REQ_PERF_EN
    logic [31:0] ar_stall_q, ar_stall_d;
    logic [31:0] aw_stall_q, aw_stall_d;

    // Saturating stall counters.
    always_comb begin
        ar_stall_d = ar_stall_q;
        aw_stall_d = aw_stall_q;
        if ((arvalid_q && !arready_i) && (ar_stall_q != 32'hFFFF_FFFF)) begin
            ar_stall_d = ar_stall_q + 32'd1;
        end else begin
            ar_stall_d = ar_stall_q;
        end
        if (((awvalid_q && !awready_i) || (wvalid_q && !wready_i)) &&
            (aw_stall_q != 32'hFFFF_FFFF)) begin
            aw_stall_d = aw_stall_q + 32'd1;
        end else begin
            aw_stall_d = aw_stall_q;
        end
    end

    // Stall counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ar_stall_q <= 32'd0;
            aw_stall_q <= 32'd0;
        end else begin
            ar_stall_q <= ar_stall_d;
            aw_stall_q <= aw_stall_d;
        end
    end

    assign ar_stall_cnt_o = ar_stall_q;
    assign aw_stall_cnt_o = aw_stall_q;
`endif

endmodule

// File: tb/tb_mem_req.sv
// Self-checking bench for mem_req: a transaction-level model compared every
// cycle, plus directed literal checks from the test plan.
module tb_mem_req;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        resp_done_i = 1'b0;
    logic        misalign_o, busy_o;
    logic [31:0] araddr_o, awaddr_o, wdata_o;
    logic [2:0]  arsize_o, awsize_o;
    logic        arvalid_o, awvalid_o, wvalid_o;
    logic        arready_i = 1'b0, awready_i = 1'b0, wready_i = 1'b0;
    logic [3:0]  wstrb_o;
`ifdef MEM_REQ_PERF_EN
    logic [31:0] ar_stall_cnt_o, aw_stall_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int ar_hi_cnt = 0;

    always #5 clock = ~clock;

    mem_req dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_size_i  (req_size_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .resp_done_i (resp_done_i),
        .misalign_o  (misalign_o),
        .busy_o      (busy_o),
        .araddr_o    (araddr_o),
        .arsize_o    (arsize_o),
        .arvalid_o   (arvalid_o),
        .arready_i   (arready_i),
        .awaddr_o    (awaddr_o),
        .awsize_o    (awsize_o),
        .awvalid_o   (awvalid_o),
        .awready_i   (awready_i),
        .wdata_o     (wdata_o),
        .wstrb_o     (wstrb_o),
        .wvalid_o    (wvalid_o),
        .wready_i    (wready_i)
`ifdef MEM_REQ_PERF_EN
        ,
        .ar_stall_cnt_o (ar_stall_cnt_o),
        .aw_stall_cnt_o (aw_stall_cnt_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: which channels are pending and what payload they carry.
    logic        m_ar = 1'b0, m_aw = 1'b0, m_w = 1'b0, m_wait = 1'b0, m_mis = 1'b0;
    logic [31:0] m_addr = 32'd0, m_data = 32'd0;
    logic [1:0]  m_size = 2'b00;
    logic [3:0]  m_strb = 4'b0000;
    wire         m_busy = m_ar | m_aw | m_w | m_wait;

    function automatic logic is_aligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b0;
        return (addr % (32'd1 << size)) == 32'd0;
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [31:0] addr);
        int nb  = 1 << size;
        int off = int'(addr % 32'd4);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [31:0] addr);
        int off = int'(addr % 32'd4);
        return 32'(d * (32'd1 << (8 * off)));
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ar <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0; m_wait <= 1'b0; m_mis <= 1'b0;
            m_addr <= 32'd0; m_data <= 32'd0; m_size <= 2'b00; m_strb <= 4'b0000;
        end else begin
            m_mis <= 1'b0;
            if (!m_busy && req_valid_i) begin
                if (!is_aligned(req_size_i, req_addr_i)) begin
                    m_mis <= 1'b1;
                end else begin
                    m_addr <= req_addr_i;
                    m_size <= req_size_i;
                    if (req_we_i) begin
                        m_aw   <= 1'b1;
                        m_w    <= 1'b1;
                        m_data <= lane_data(req_wdata_i, req_addr_i);
                        m_strb <= lane_strb(req_size_i, req_addr_i);
                    end else begin
                        m_ar <= 1'b1;
                    end
                end
            end
            if (m_ar && arready_i) begin
                m_ar   <= 1'b0;
                m_wait <= 1'b1;
            end
            if (m_aw || m_w) begin
                if (m_aw && awready_i) m_aw <= 1'b0;
                if (m_w && wready_i)   m_w  <= 1'b0;
                if (!(m_aw && !awready_i) && !(m_w && !wready_i)) m_wait <= 1'b1;
            end
            if (m_wait && resp_done_i) m_wait <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (arvalid_o) ar_hi_cnt <= ar_hi_cnt + 1;
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        chk("busy", busy_o, m_busy);
        chk("req_ready", req_ready_o, !m_busy);
        chk("arvalid", arvalid_o, m_ar);
        chk("awvalid", awvalid_o, m_aw);
        chk("wvalid", wvalid_o, m_w);
        chk("misalign", misalign_o, m_mis);
        if (m_ar) begin
            chk("araddr", araddr_o, m_addr);
            chk("arsize", arsize_o, {1'b0, m_size});
        end
        if (m_aw) begin
            chk("awaddr", awaddr_o, m_addr);
            chk("awsize", awsize_o, {1'b0, m_size});
        end
        if (m_w) begin
            chk("wdata", wdata_o, m_data);
            chk("wstrb", wstrb_o, m_strb);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] data);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_size_i  = size;
        req_addr_i  = addr;
        req_wdata_i = data;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic resp();
        resp_done_i = 1'b1;
        tick();
        resp_done_i = 1'b0;
    endtask

    int a0;
`ifdef MEM_REQ_PERF_EN
    logic [31:0] c_ar, c_aw;
`endif

    initial begin
        repeat (2) tick();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_arvalid", arvalid_o, 1'b0);
        chk("rst_awvalid", awvalid_o, 1'b0);
        chk("rst_wvalid", wvalid_o, 1'b0);
        chk("rst_araddr", araddr_o, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wstrb", wstrb_o, 4'b0000);
        reset = 1'b1;
        tick();

        // Load word, AR stalled 3 cycles; a stray resp_done while in RD_ADDR is ignored.
        a0 = ar_hi_cnt;
        issue(1'b0, 2'b10, 32'h8000_0004, 32'd0);
        chk("t1_araddr", araddr_o, 32'h8000_0004);
        chk("t1_arsize", arsize_o, 3'b010);
        resp();
        repeat (2) tick();
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        chk("t1_ar_cycles", 32'(ar_hi_cnt - a0), 32'd4);
        chk("t1_busy_wait", busy_o, 1'b1);
        tick();
        chk("t1_ready_pre", req_ready_o, 1'b0);
        resp();
        chk("t1_ready_after", req_ready_o, 1'b1);

        // Store byte 0xAB at ...3, both channels handshake together.
        issue(1'b1, 2'b00, 32'h8000_0003, 32'h0000_00AB);
        chk("t2_wdata", wdata_o, 32'hAB00_0000);
        chk("t2_wstrb", wstrb_o, 4'b1000);
        chk("t2_awsize", awsize_o, 3'b000);
        awready_i = 1'b1;
        wready_i  = 1'b1;
        tick();
        awready_i = 1'b0;
        wready_i  = 1'b0;
        chk("t2_awvalid_drop", awvalid_o, 1'b0);
        chk("t2_busy", busy_o, 1'b1);
        tick();
        resp();
        tick();

        // Store half at ...2, AW two cycles ahead of W.
        issue(1'b1, 2'b01, 32'h8000_0002, 32'h0000_1234);
        chk("t3_wdata", wdata_o, 32'h1234_0000);
        chk("t3_wstrb", wstrb_o, 4'b1100);
        awready_i = 1'b1;
        tick();
        awready_i = 1'b0;
        chk("t3_awvalid_drop", awvalid_o, 1'b0);
        chk("t3_wvalid_hold", wvalid_o, 1'b1);
        tick();
        wready_i = 1'b1;
        tick();
        wready_i = 1'b0;
        chk("t3_wvalid_drop", wvalid_o, 1'b0);
        chk("t3_busy", busy_o, 1'b1);
        tick();
        resp();
        tick();

        // Store word with W before AW.
        issue(1'b1, 2'b10, 32'h8000_0010, 32'hDEAD_BEEF);
        chk("t3b_wstrb", wstrb_o, 4'b1111);
        wready_i = 1'b1;
        tick();
        wready_i  = 1'b0;
        awready_i = 1'b1;
        tick();
        awready_i = 1'b0;
        chk("t3b_busy", busy_o, 1'b1);
        resp();
        tick();

        // Misaligned requests: half at ...1, word at ...2, size 11.
        a0 = ar_hi_cnt;
        issue(1'b0, 2'b01, 32'h8000_0001, 32'd0);
        chk("t4_misalign", misalign_o, 1'b1);
        chk("t4_ready", req_ready_o, 1'b1);
        chk("t4_arvalid", arvalid_o, 1'b0);
        tick();
        chk("t4_misalign_pulse", misalign_o, 1'b0);
        issue(1'b0, 2'b10, 32'h8000_0002, 32'd0);
        chk("t4_word_mis", misalign_o, 1'b1);
        issue(1'b1, 2'b11, 32'h8000_0000, 32'h5555_5555);
        chk("t4_size3_mis", misalign_o, 1'b1);
        chk("t4_size3_awvalid", awvalid_o, 1'b0);
        tick();
        chk("t4_no_ar", 32'(ar_hi_cnt - a0), 32'd0);

        // Reset while in WR_ADDR_DATA.
        issue(1'b1, 2'b10, 32'h8000_0020, 32'h1122_3344);
        chk("t5_awvalid_pre", awvalid_o, 1'b1);
        reset = 1'b0;
        #1;
        chk("t5_awvalid_rst", awvalid_o, 1'b0);
        chk("t5_wvalid_rst", wvalid_o, 1'b0);
        chk("t5_busy_rst", busy_o, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        chk("t5_ready_after", req_ready_o, 1'b1);
        chk("t5_awvalid_after", awvalid_o, 1'b0);

        // Load with 5 AR stall cycles.
`ifdef MEM_REQ_PERF_EN
        c_ar = ar_stall_cnt_o;
        c_aw = aw_stall_cnt_o;
`endif
        a0 = ar_hi_cnt;
        issue(1'b0, 2'b00, 32'h8000_0041, 32'd0);
        repeat (5) tick();
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        chk("t6_ar_cycles", 32'(ar_hi_cnt - a0), 32'd6);
`ifdef MEM_REQ_PERF_EN
        chk("t6_ar_stall", ar_stall_cnt_o - c_ar, 32'd5);
        chk("t6_aw_stall", aw_stall_cnt_o - c_aw, 32'd0);
`endif
        tick();
        resp();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
